// File: rtl/eq_param_ctrl.sv
// Front-panel controller for the parametric EQ: edge-detects buttons, edits a per-band
// parameter table and hands each value change to the coefficient engine. Optional: AUTOREPEAT_EN.
module eq_param_ctrl #(
  parameter int          NBANDS        = 4,
  parameter int          VAL_W         = 8,
  parameter int          STEP          = 1,
  parameter int unsigned HOLD_CYCLES   = 13500000,
  parameter int unsigned REPEAT_CYCLES = 2700000,
  localparam int         BW            = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_enter,
  output logic [BW-1:0]    band_sel,
  output logic [1:0]       param_sel,
  output logic [VAL_W-1:0] cur_value,
  output logic             upd_req,
  output logic [BW-1:0]    upd_band,
  output logic [1:0]       upd_param,
  output logic [VAL_W-1:0] upd_value,
  input  logic             upd_ack,
  output logic             busy
);

  // state | meaning
  // IDLE  | accepting presses and repeat steps, selectors editable
  // REQ   | update pending at the coefficient engine, waiting for upd_ack
  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [VAL_W-1:0] STEP_V = VAL_W'(STEP);
  localparam logic [VAL_W-1:0] MAX_V  = '1;
  localparam logic [VAL_W-1:0] DEF_V  = {1'b1, {(VAL_W-1){1'b0}}};

  if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_timing
    $error("eq_param_ctrl: HOLD_CYCLES and REPEAT_CYCLES must be nonzero");
  end

  state_t state, state_next;

  logic [4:0] btn_now, btn_prev, press;
  logic w_enter, w_up, w_down, w_right, w_left;
  logic idle, step_up, step_down, do_step, rep_fire, rep_up;
  logic [VAL_W-1:0] new_val;
  logic [VAL_W-1:0] tbl [NBANDS][3];

  assign btn_now = {btn_enter, btn_up, btn_down, btn_right, btn_left};
  assign press   = btn_now & ~btn_prev;

  always_comb begin
    w_enter = press[4];
    w_up    = press[3] & ~press[4];
    w_down  = press[2] & ~|press[4:3];
    w_right = press[1] & ~|press[4:2];
    w_left  = press[0] & ~|press[4:1];
  end

`ifdef AUTOREPEAT_EN
  logic        rep_on, rep_level;
  logic [31:0] rep_cnt;

  assign rep_level = rep_up ? btn_up : btn_down;
  assign rep_fire  = rep_on & rep_level & ~(|press) & (rep_cnt == '0);

  // Down-counter: first step HOLD_CYCLES after the press, then every REPEAT_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_on  <= 1'b0;
      rep_up  <= 1'b0;
      rep_cnt <= '0;
    end else if (idle && (w_up || w_down)) begin
      rep_on  <= 1'b1;
      rep_up  <= w_up;
      rep_cnt <= 32'(HOLD_CYCLES - 1);
    end else if ((|press) || !rep_level) begin
      rep_on  <= 1'b0;
      rep_cnt <= '0;
    end else if (rep_on) begin
      if (rep_cnt == '0) rep_cnt <= 32'(REPEAT_CYCLES - 1);
      else               rep_cnt <= rep_cnt - 32'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
  assign rep_up   = 1'b0;
`endif

  assign idle      = (state == S_IDLE);
  assign step_up   = idle & (w_up   | (rep_fire &  rep_up));
  assign step_down = idle & (w_down | (rep_fire & ~rep_up));
  assign cur_value = tbl[band_sel][param_sel];

  always_comb begin
    new_val = cur_value;
    if (step_up)
      new_val = (cur_value > MAX_V - STEP_V) ? MAX_V : cur_value + STEP_V;
    else if (step_down)
      new_val = (cur_value < STEP_V) ? '0 : cur_value - STEP_V;
  end

  // A step that lands on the old value (saturated) produces no request.
  assign do_step = (step_up | step_down) & (new_val != cur_value);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (do_step) state_next = S_REQ;
      S_REQ:  if (upd_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    upd_req = (state == S_REQ);
    busy    = (state == S_REQ);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_prev  <= btn_now;
      band_sel  <= '0;
      param_sel <= 2'd0;
      upd_band  <= '0;
      upd_param <= 2'd0;
      upd_value <= '0;
      for (int b = 0; b < NBANDS; b++)
        for (int p = 0; p < 3; p++)
          tbl[b][p] <= DEF_V;
    end else begin
      btn_prev <= btn_now;
      if (idle) begin
        if (w_enter)
          band_sel <= (band_sel == BW'(NBANDS - 1)) ? '0 : band_sel + 1'b1;
        if (w_right)
          param_sel <= (param_sel == 2'd2) ? 2'd0 : param_sel + 2'd1;
        if (w_left)
          param_sel <= (param_sel == 2'd0) ? 2'd2 : param_sel - 2'd1;
        if (do_step) begin
          tbl[band_sel][param_sel] <= new_val;
          upd_band  <= band_sel;
          upd_param <= param_sel;
          upd_value <= new_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_eq_param_ctrl.sv
// Scoreboard bench for eq_param_ctrl: expected updates queued at stimulus time,
// compared as upd_req rises; engine acks 2 cycles after req (or instantly).
module tb_eq_param_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_enter = 0;
  logic upd_ack = 1'b0;
  logic [1:0] band_sel, param_sel, upd_band, upd_param;
  logic [7:0] cur_value, upd_value;
  logic upd_req, busy;

  always #5 clock = ~clock;

  eq_param_ctrl #(
    .NBANDS(4), .VAL_W(8), .STEP(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_enter(btn_enter),
    .band_sel(band_sel), .param_sel(param_sel), .cur_value(cur_value),
    .upd_req(upd_req), .upd_band(upd_band), .upd_param(upd_param),
    .upd_value(upd_value), .upd_ack(upd_ack), .busy(busy)
  );

  localparam logic [4:0] B_ENTER = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00001;

  typedef struct packed {
    logic [1:0] band;
    logic [1:0] param;
    logic [7:0] value;
  } upd_t;

  int errors = 0, checks = 0, req_count = 0, cyc = 0;
  upd_t exp_q[$];
  int   rise_q[$];
  int   ref_tbl [4][3];
  int   ref_band = 0, ref_param = 0;
  bit   ack_instant = 0, abort_ok = 0;

  always @(posedge clock) cyc++;

  // Engine model + scoreboard consumer.
  logic req_d = 1'b0;
  int   req_len = 0;
  upd_t held;
  always @(negedge clock) begin
    if (upd_req && !req_d) begin
      req_count++;
      rise_q.push_back(cyc);
      req_len = 1;
      held = {upd_band, upd_param, upd_value};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got band=%0d param=%0d value=%0d, required no request",
                 upd_band, upd_param, upd_value);
      end else begin
        upd_t e;
        e = exp_q.pop_front();
        if ({upd_band, upd_param, upd_value} !== e) begin
          errors++;
          $display("FAIL sb_update: got band=%0d param=%0d value=%0d, required band=%0d param=%0d value=%0d",
                   upd_band, upd_param, upd_value, e.band, e.param, e.value);
        end
      end
    end else if (upd_req) begin
      req_len++;
      checks++;
      if ({upd_band, upd_param, upd_value} !== held) begin
        errors++;
        $display("FAIL upd_stable: got %h, required %h", {upd_band, upd_param, upd_value}, held);
      end
    end else if (req_d) begin
      if (!abort_ok) begin
        checks++;
        if (req_len !== (ack_instant ? 1 : 2)) begin
          errors++;
          $display("FAIL req_length: got %0d cycles, required %0d", req_len, ack_instant ? 1 : 2);
        end
      end
      if (!ack_instant) upd_ack = 1'b0;
    end
    if (upd_req && !ack_instant && req_len == 2) upd_ack = 1'b1;
    req_d = upd_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int p = 0; p < 3; p++)
        ref_tbl[b][p] = 128;
    ref_band = 0;
    ref_param = 0;
  endtask

  task automatic model_step(input bit up);
    int old_v, nv;
    upd_t e;
    old_v = ref_tbl[ref_band][ref_param];
    nv = up ? ((old_v == 255) ? 255 : old_v + 1) : ((old_v == 0) ? 0 : old_v - 1);
    if (nv != old_v) begin
      ref_tbl[ref_band][ref_param] = nv;
      e.band = 2'(ref_band);
      e.param = 2'(ref_param);
      e.value = 8'(nv);
      exp_q.push_back(e);
    end
  endtask

  task automatic press(input logic [4:0] m);
    {btn_enter, btn_up, btn_down, btn_right, btn_left} = m;
    @(negedge clock);
    {btn_enter, btn_up, btn_down, btn_right, btn_left} = 5'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (upd_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (upd_req) begin
      errors++;
      $display("FAIL %s_timeout: upd_req still 1 after 20 cycles, required 0", tag);
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (band_sel !== 2'd0) begin errors++; $display("FAIL reset_band: got %0d, required 0", band_sel); end
    checks++; if (param_sel !== 2'd0) begin errors++; $display("FAIL reset_param: got %0d, required 0", param_sel); end
    checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", upd_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if ({upd_band, upd_param, upd_value} !== 12'h0) begin errors++; $display("FAIL reset_upd: got %h, required 0", {upd_band, upd_param, upd_value}); end
    checks++; if (cur_value !== 8'd128) begin errors++; $display("FAIL reset_value: got %0d, required 128", cur_value); end
    reset = 1'b0;
    model_reset();
    tick(1);
  endtask

  task automatic test_single_up();
    int c0 = req_count;
    model_step(1);
    btn_up = 1'b1;
    @(negedge clock);
    checks++; if (upd_req !== 1'b1) begin errors++; $display("FAIL up_req_latency: got %b, required 1", upd_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy: got %b, required 1", busy); end
    btn_up = 1'b0;
    @(negedge clock);
    wait_idle("up");
    checks++; if (cur_value !== 8'd129) begin errors++; $display("FAIL up_value: got %0d, required 129", cur_value); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_after_ack: got %b, required 0", busy); end
    checks++; if (req_count - c0 !== 1) begin errors++; $display("FAIL up_req_count: got %0d, required 1", req_count - c0); end
  endtask

  task automatic test_selectors();
    int exp_b[5] = '{1, 2, 3, 0, 1};
    int c0 = req_count;
    for (int i = 0; i < 5; i++) begin
      press(B_ENTER);
      checks++; if (band_sel !== 2'(exp_b[i])) begin errors++; $display("FAIL enter_%0d: got band %0d, required %0d", i, band_sel, exp_b[i]); end
    end
    ref_band = 1;
    press(B_LEFT);
    checks++; if (param_sel !== 2'd2) begin errors++; $display("FAIL left_wrap: got %0d, required 2", param_sel); end
    press(B_RIGHT);
    checks++; if (param_sel !== 2'd0) begin errors++; $display("FAIL right_wrap: got %0d, required 0", param_sel); end
    ref_param = 0;
    checks++; if (req_count - c0 !== 0 || upd_req !== 1'b0) begin errors++; $display("FAIL sel_no_req: got %0d reqs, required 0", req_count - c0); end
  endtask

  task automatic test_saturation();
    int c0 = req_count;
    for (int i = 0; i < 128; i++) begin
      model_step(0);
      press(B_DOWN);
      wait_idle("down");
    end
    checks++; if (cur_value !== 8'd0) begin errors++; $display("FAIL down_floor: got %0d, required 0", cur_value); end
    checks++; if (req_count - c0 !== 128) begin errors++; $display("FAIL down_count: got %0d, required 128", req_count - c0); end
    model_step(0);
    press(B_DOWN);
    tick(1);
    checks++; if (upd_req !== 1'b0 || req_count - c0 !== 128) begin errors++; $display("FAIL down_sat_req: got %0d reqs, required 128", req_count - c0); end
    press(B_RIGHT);
    ref_param = 1;
    c0 = req_count;
    for (int i = 0; i < 127; i++) begin
      model_step(1);
      press(B_UP);
      wait_idle("up_sat");
    end
    checks++; if (cur_value !== 8'd255) begin errors++; $display("FAIL up_ceiling: got %0d, required 255", cur_value); end
    model_step(1);
    press(B_UP);
    tick(1);
    checks++; if (upd_req !== 1'b0 || req_count - c0 !== 127) begin errors++; $display("FAIL up_sat_req: got %0d reqs, required 127", req_count - c0); end
  endtask

  task automatic test_priority();
    int c0 = req_count;
    press(B_UP | B_DOWN | B_ENTER);
    ref_band = 2;
    checks++; if (band_sel !== 2'd2) begin errors++; $display("FAIL prio_band: got %0d, required 2", band_sel); end
    checks++; if (param_sel !== 2'd1) begin errors++; $display("FAIL prio_param: got %0d, required 1", param_sel); end
    checks++; if (upd_req !== 1'b0 || req_count - c0 !== 0) begin errors++; $display("FAIL prio_no_req: got %0d reqs, required 0", req_count - c0); end
    model_step(0);
    btn_down = 1'b1;
    @(negedge clock);
    btn_down = 1'b0;
    btn_up = 1'b1;
    @(negedge clock);
    btn_up = 1'b0;
    checks++; if (upd_req !== 1'b1 || upd_value !== 8'd127) begin errors++; $display("FAIL req_hold: got req=%b value=%0d, required req=1 value=127", upd_req, upd_value); end
    wait_idle("drop");
    tick(2);
    checks++; if (cur_value !== 8'd127) begin errors++; $display("FAIL drop_in_req: got %0d, required 127", cur_value); end
    checks++; if (req_count - c0 !== 1) begin errors++; $display("FAIL drop_count: got %0d reqs, required 1", req_count - c0); end
  endtask

  task automatic test_reset_behaviour();
    int c0 = req_count;
    abort_ok = 1;
    btn_up = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    tick(3);
    checks++; if (upd_req !== 1'b0 || req_count - c0 !== 0) begin errors++; $display("FAIL held_through_reset: got %0d reqs, required 0", req_count - c0); end
    checks++; if (cur_value !== 8'd128) begin errors++; $display("FAIL held_value: got %0d, required 128", cur_value); end
    btn_up = 1'b0;
    tick(1);
    model_step(1);
    btn_up = 1'b1;
    @(negedge clock);
    checks++; if (upd_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b, required 1", upd_req); end
    btn_up = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (upd_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_req: got req=%b busy=%b, required 0 0", upd_req, busy); end
    tick(1);
    reset = 1'b0;
    model_reset();
    tick(1);
    abort_ok = 0;
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 3; p++) begin
        checks++; if (cur_value !== 8'd128) begin errors++; $display("FAIL default_b%0d_p%0d: got %0d, required 128", b, p, cur_value); end
        press(B_RIGHT);
      end
      press(B_ENTER);
    end
  endtask

  task automatic test_autorepeat();
    int c0, t0, n_exp, exp_final;
    int gaps[5] = '{10, 4, 4, 4, 4};
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    tick(1);
    ack_instant = 1;
    upd_ack = 1'b1;
    rise_q.delete();
    c0 = req_count;
`ifdef AUTOREPEAT_EN
    n_exp = 6;
    exp_final = 134;
`else
    n_exp = 1;
    exp_final = 129;
`endif
    for (int i = 0; i < n_exp; i++) model_step(1);
    t0 = cyc;
    btn_up = 1'b1;
    repeat (30) @(negedge clock);
    btn_up = 1'b0;
    tick(5);
    checks++; if (cur_value !== 8'(exp_final)) begin errors++; $display("FAIL repeat_value: got %0d, required %0d", cur_value, exp_final); end
    checks++; if (req_count - c0 !== n_exp) begin errors++; $display("FAIL repeat_count: got %0d, required %0d", req_count - c0, n_exp); end
    if (rise_q.size() > 0) begin
      checks++; if (rise_q[0] !== t0 + 1) begin errors++; $display("FAIL repeat_first: got cycle %0d, required %0d", rise_q[0], t0 + 1); end
    end
    for (int i = 1; i < rise_q.size() && i <= 5; i++) begin
      checks++; if (rise_q[i] - rise_q[i-1] !== gaps[i-1]) begin errors++; $display("FAIL repeat_gap_%0d: got %0d, required %0d", i, rise_q[i] - rise_q[i-1], gaps[i-1]); end
    end
    upd_ack = 1'b0;
    ack_instant = 0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_selectors();
    test_saturation();
    test_priority();
    test_reset_behaviour();
    test_autorepeat();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending updates, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
